// File: rtl/prog_loader_pipeline.sv
// Host-driven program/data loader: parses header/data/checksum frames into
// imem/dmem write strobes and holds the core in reset until a GO command.
module prog_loader_pipeline #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           word_count
);

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_CSUM = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  target_q, target_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [13:0]           n_q, n_d;
  logic [13:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                  dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic                  core_hold_q, core_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
  logic [15:0]           word_count_q, word_count_d;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign in_ready = (state_q != S_RUN);
  assign xfer     = in_valid & in_ready;
  // Address wraps modulo the memory size by truncation.
  assign wr_addr  = base_q + idx_q[ADDR_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    base_d       = base_q;
    n_d          = n_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    core_hold_d  = core_hold_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
    word_count_d = word_count_q;
    case (state_q)
      S_HDR: begin
        if (xfer) begin
          if (in_data[30]) begin
            // A GO after a checksum failure is swallowed; core stays held.
            if (!load_error_q) begin
              state_d     = S_RUN;
              core_hold_d = 1'b0;
            end
          end else begin
            target_d = in_data[31];
            base_d   = in_data[ADDR_WIDTH-1:0];
            n_d      = in_data[29:16];
            idx_d    = '0;
            csum_d   = '0;
            state_d  = (in_data[29:16] != 14'd0) ? S_DATA : S_CSUM;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (target_q) begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = wr_addr;
            dmem_wdata_d = in_data;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wr_addr;
            imem_wdata_d = in_data;
          end
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + 14'd1;
          if (idx_q + 14'd1 == n_q) state_d = S_CSUM;
          if (word_count_q != '1) word_count_d = word_count_q + 16'd1;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (in_data == csum_q) load_done_d  = 1'b1;
          else                   load_error_d = 1'b1;
          state_d = S_HDR;
        end
      end
      S_RUN: begin
        core_hold_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HDR;
      target_q     <= 1'b0;
      base_q       <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      base_q       <= base_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      word_count_q <= word_count_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign word_count = word_count_q;

endmodule

// File: doc/prog_loader_pipeline.md
Name: prog_loader_pipeline

Overview:
- Hardware program/data loader for the pipelined RISC-V core.
- Accepts a word stream from a host-side valid/ready interface and writes it into instruction memory or data memory.
- Holds the core in reset while loading, then releases it on a GO command.
- It is the write-side counterpart of the bench's memory/register inspection: it fills the memories that the core later reads.

Parameters:
- ADDR_WIDTH, 8, word-address width of each memory (256 words).
- DATA_WIDTH, 32, memory word width; header layout assumes 32.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  host word valid
- in_data  in  32  host word
- in_ready  out  1  loader can accept a word
- imem_we  out  1  instruction-memory write strobe, one cycle
- imem_addr  out  ADDR_WIDTH  instruction-memory word address
- imem_wdata  out  32  instruction-memory write data
- dmem_we  out  1  data-memory write strobe, one cycle
- dmem_addr  out  ADDR_WIDTH  data-memory word address
- dmem_wdata  out  32  data-memory write data
- core_hold  out  1  1 = keep core in reset
- load_done  out  1  pulse: frame accepted with good checksum
- load_error  out  1  sticky checksum-mismatch flag
- word_count  out  16  total data words written since reset, saturating at 0xFFFF

Behaviour:
- Handshake:
  - A word transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready=1 in HDR, DATA and CSUM; in_ready=0 in RUN.
  - The host may hold in_valid high continuously; there is no backpressure other than RUN.
- Header word fields:
  - [31] target: 0 = imem, 1 = dmem.
  - [30] GO.
  - [29:16] N, the data word count (0..16383).
  - [ADDR_WIDTH-1:0] base word address.
  - Remaining bits are ignored.
- States:
  - HDR (reset state). On transfer:
    - If GO=1 and load_error=0, go to RUN.
    - If GO=1 and load_error=1, the word is consumed and the loader stays in HDR.
    - Otherwise latch target, base and N, clear the running XOR, set the index to 0. Go to DATA if N>0, else CSUM.
  - DATA: each transfer writes the word to memory at (base+index) mod 2^ADDR_WIDTH. The address wraps silently. XOR the word into the running checksum and increment the index. After the Nth word, go to CSUM.
  - CSUM: on transfer, compare the word to the running XOR.
    - Equal: pulse load_done for one cycle.
    - Mismatch: set load_error (it remains set until reset).
    - Either way, return to HDR. Words already written are not rolled back.
  - RUN: core_hold=0 and in_ready=0. Leave RUN only on reset.
- Write timing:
  - Strobe, address and data are registered.
  - A word accepted at edge k gives imem_we or dmem_we = 1 in the cycle following edge k, with matching addr/wdata.
  - Only the selected memory's strobe asserts; the other strobe stays 0.
  - Back-to-back transfers give back-to-back strobes.
  - addr/wdata hold their last value when the strobe is 0.
- word_count increments once per DATA transfer and saturates at 0xFFFF.
- Reset values and mid-operation reset:
  - Reset values: state=HDR, in_ready=1 after reset release, all strobes 0, addr/wdata 0, core_hold=1, load_done=0, load_error=0, word_count=0.
  - Reset asserted mid-frame or in RUN aborts immediately: core_hold returns to 1 asynchronously and no further strobes occur.
- core_hold is registered and drops the cycle after the GO transfer edge.

Test Plan:
- Reset, then header 0x0003_0000 (imem, N=3, base 0), data 0x00002503, 0x00402583, 0x40B50633, checksum = XOR of the three -> imem_we on 3 consecutive cycles at addr 0,1,2 with those data; load_done pulses once; word_count=3; core_hold=1.
- Header 0x8002_0000 (dmem, N=2, base 0), data 10 and 3, checksum 9 -> dmem[0]=10, dmem[1]=3, imem_we never asserts; then header 0x4000_0000 (GO) -> core_hold=0 next cycle and in_ready=0.
- Header 0x8002_00FF (dmem, N=2, base 255), data 0xA and 0xB -> writes at addr 255 then 0 (wrap); good checksum 0x1 -> load_done pulses.
- Header 0x0001_0004, data 0x1234, checksum 0x0 -> load_error=1, imem[4]=0x1234 kept; subsequent GO header ignored, core_hold stays 1.
- Header 0x0000_0010 (N=0), checksum 0 -> no strobes, load_done pulses; in_valid toggling every other cycle during a 4-word frame -> strobes only follow accepted words.
- Assert reset mid-DATA after 1 of 3 words -> strobes stop, core_hold=1, word_count=0, and the loader accepts a fresh header after release.
